// File: rtl/red_blob_tracker.sv
// red_blob_tracker: reduces a per-pixel red mask to bounding box, count and centroid once per frame.
// Latency: results and oVALID update 59 cycles after the iEOF edge (29+29 cycle restoring divide).
// Backpressure: none; an iEOF arriving while a result is still being computed is dropped (oDROP).
//
// Ports: iCLK/iRST_N clock and async active-low reset; iDVAL/iX/iY/iMASK pixel stream;
//   iEOF end-of-frame pulse; oX_MIN..oY_MAX/oCNT/oCX/oCY/oFOUND published frame result;
//   oVALID result-update pulse; oDROP frame-discarded pulse; oOVL registered box-perimeter overlay.
// Optional feature: define BBOX_OVERLAY_EN to build the overlay comparators (else oOVL tied 0).
module red_blob_tracker #(
  parameter int MIN_COUNT = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iDVAL,
  input  logic [9:0]  iX,
  input  logic [9:0]  iY,
  input  logic        iMASK,
  input  logic        iEOF,
  output logic [9:0]  oX_MIN,
  output logic [9:0]  oX_MAX,
  output logic [9:0]  oY_MIN,
  output logic [9:0]  oY_MAX,
  output logic [18:0] oCNT,
  output logic [9:0]  oCX,
  output logic [9:0]  oCY,
  output logic        oFOUND,
  output logic        oVALID,
  output logic        oDROP,
  output logic        oOVL
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} stateT;

  stateT       state, nextState;
  logic        counted, busy, snapshot, startPend;
  logic        loadX, switchY, publish, lastStep;

  // running accumulators for the frame being received
  logic [18:0] cnt, cntNext;
  logic [28:0] sumX, sumY, sumXNext, sumYNext;
  logic [9:0]  xMin, xMax, yMin, yMax;
  logic [9:0]  xMinNext, xMaxNext, yMinNext, yMaxNext;

  // snapshot of the frame being divided
  logic [18:0] shCnt;
  logic [28:0] shSumX, shSumY;
  logic [9:0]  shXMin, shXMax, shYMin, shYMax;

  // shared restoring divider
  logic [28:0] divDividend;
  logic [18:0] divRem, remDiff, remNext;
  logic [19:0] remSh;
  logic [9:0]  divQ, qNext, quoX;
  logic [4:0]  stepCnt;
  logic        ge;

  assign counted  = iDVAL & iMASK;
  // the start-pending cycle counts as busy so a back-to-back iEOF cannot overwrite the snapshot
  assign busy     = (state != IDLE) | startPend;
  assign snapshot = iEOF & ~busy;
  assign lastStep = (stepCnt == 5'd28);

  always_comb begin
    cntNext  = cnt;
    sumXNext = sumX;
    sumYNext = sumY;
    xMinNext = xMin;
    xMaxNext = xMax;
    yMinNext = yMin;
    yMaxNext = yMax;
    if (counted) begin
      cntNext  = cnt + 19'd1;
      sumXNext = sumX + {19'd0, iX};
      sumYNext = sumY + {19'd0, iY};
      xMinNext = (iX < xMin) ? iX : xMin;
      xMaxNext = (iX > xMax) ? iX : xMax;
      yMinNext = (iY < yMin) ? iY : yMin;
      yMaxNext = (iY > yMax) ? iY : yMax;
    end
  end

  // a pixel counted on the iEOF edge belongs to the closing frame (captured via *Next)
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt <= '0; sumX <= '0; sumY <= '0;
      xMin <= 10'd1023; yMin <= 10'd1023; xMax <= '0; yMax <= '0;
      shCnt <= '0; shSumX <= '0; shSumY <= '0;
      shXMin <= 10'd1023; shYMin <= 10'd1023; shXMax <= '0; shYMax <= '0;
      startPend <= 1'b0;
      oDROP <= 1'b0;
    end else begin
      if (iEOF) begin
        cnt <= '0; sumX <= '0; sumY <= '0;
        xMin <= 10'd1023; yMin <= 10'd1023; xMax <= '0; yMax <= '0;
      end else begin
        cnt <= cntNext; sumX <= sumXNext; sumY <= sumYNext;
        xMin <= xMinNext; xMax <= xMaxNext; yMin <= yMinNext; yMax <= yMaxNext;
      end
      if (snapshot) begin
        shCnt <= cntNext; shSumX <= sumXNext; shSumY <= sumYNext;
        shXMin <= xMinNext; shXMax <= xMaxNext; shYMin <= yMinNext; shYMax <= yMaxNext;
      end
      if (snapshot)   startPend <= 1'b1;
      else if (loadX) startPend <= 1'b0;
      oDROP <= iEOF & busy;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    loadX     = 1'b0;
    switchY   = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE:  if (startPend) begin nextState = DIV_X; loadX = 1'b1; end
      DIV_X: if (lastStep) begin nextState = DIV_Y; switchY = 1'b1; end
      DIV_Y: if (lastStep) begin nextState = DONE; publish = 1'b1; end
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // one restoring step: shift in next dividend bit, subtract divisor if it fits.
  // remDiff is taken mod 2^19, which is exact whenever ge selects it (result < divisor).
  always_comb begin
    remSh   = {divRem, divDividend[28]};
    ge      = (remSh >= {1'b0, shCnt});
    remDiff = remSh[18:0] - shCnt;
    remNext = ge ? remDiff : remSh[18:0];
    qNext   = {divQ[8:0], ge};
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      divDividend <= '0; divRem <= '0; divQ <= '0; stepCnt <= '0; quoX <= '0;
    end else if (loadX || switchY) begin
      divDividend <= loadX ? shSumX : shSumY;
      divRem      <= '0;
      divQ        <= '0;
      stepCnt     <= '0;
      if (switchY) quoX <= qNext;
    end else if (state == DIV_X || state == DIV_Y) begin
      divDividend <= {divDividend[27:0], 1'b0};
      divRem      <= remNext;
      divQ        <= qNext;
      stepCnt     <= stepCnt + 5'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oX_MIN <= '0; oX_MAX <= '0; oY_MIN <= '0; oY_MAX <= '0;
      oCNT <= '0; oCX <= '0; oCY <= '0; oFOUND <= 1'b0; oVALID <= 1'b0;
    end else begin
      oVALID <= publish;
      if (publish) begin
        oX_MIN <= shXMin; oX_MAX <= shXMax; oY_MIN <= shYMin; oY_MAX <= shYMax;
        oCNT   <= shCnt;
        // divide by zero yields all-ones quotient; an empty frame reports centroid 0
        oCX    <= (shCnt == 19'd0) ? 10'd0 : quoX;
        oCY    <= (shCnt == 19'd0) ? 10'd0 : qNext;
        oFOUND <= (shCnt >= 19'(MIN_COUNT));
      end
    end
  end

`ifdef BBOX_OVERLAY_EN
  logic onVert, onHorz;
  always_comb begin
    onVert = ((iX == oX_MIN) || (iX == oX_MAX)) && (iY >= oY_MIN) && (iY <= oY_MAX);
    onHorz = ((iY == oY_MIN) || (iY == oY_MAX)) && (iX >= oX_MIN) && (iX <= oX_MAX);
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) oOVL <= 1'b0;
    else         oOVL <= iDVAL & oFOUND & (onVert | onHorz);
  end
`else
  assign oOVL = 1'b0;
`endif

endmodule

// File: tb/tb_red_blob_tracker.sv
// Bench for red_blob_tracker: directed frames, expected results queued at stimulus time,
// checked by an independent monitor on oVALID / oDROP (value and cycle of arrival).
module tb_red_blob_tracker;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iDVAL = 1'b0, iMASK = 1'b0, iEOF = 1'b0;
  logic [9:0]  iX = '0, iY = '0;
  logic [9:0]  oX_MIN, oX_MAX, oY_MIN, oY_MAX, oCX, oCY;
  logic [18:0] oCNT;
  logic        oFOUND, oVALID, oDROP, oOVL;

  red_blob_tracker #(.MIN_COUNT(64)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iDVAL(iDVAL), .iX(iX), .iY(iY), .iMASK(iMASK), .iEOF(iEOF),
    .oX_MIN(oX_MIN), .oX_MAX(oX_MAX), .oY_MIN(oY_MIN), .oY_MAX(oY_MAX), .oCNT(oCNT),
    .oCX(oCX), .oCY(oCY), .oFOUND(oFOUND), .oVALID(oVALID), .oDROP(oDROP), .oOVL(oOVL)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int xmin, xmax, ymin, ymax, cnt, cx, cy, found, cyc;
  } resT;

  resT resQ[$];
  int  dropQ[$];
  int  cyc = 0;
  int  lastEdge = 0;
  int  nChecks = 0;
  int  nPass = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic pix(input logic d, input int x, input int y, input logic m, input logic e);
    iDVAL = d; iX = 10'(x); iY = 10'(y); iMASK = m; iEOF = e;
    @(posedge iCLK); #1;
    lastEdge = cyc;
    iDVAL = 1'b0; iMASK = 1'b0; iEOF = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge iCLK); #1; end
  endtask

  task automatic expRes(input int xmin, input int xmax, input int ymin, input int ymax,
                        input int cnt, input int cx, input int cy, input int found, input int c);
    resT r;
    r.xmin = xmin; r.xmax = xmax; r.ymin = ymin; r.ymax = ymax;
    r.cnt = cnt; r.cx = cx; r.cy = cy; r.found = found; r.cyc = c;
    resQ.push_back(r);
  endtask

  // 10x10 red block at x=100..109, y=200..209 with unmasked margin pixels around it
  task automatic block10;
    pix(1'b0, 5, 5, 1'b1, 1'b0);  // masked but not valid: must not count
    for (int y = 200; y <= 209; y++)
      for (int x = 98; x <= 111; x++)
        pix(1'b1, x, y, (x >= 100 && x <= 109), 1'b0);
  endtask

  task automatic rowRun(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) pix(1'b1, x, y, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (resQ.size() > 0 || dropQ.size() > 0); i++) @(posedge iCLK);
    #1;
    chk(name, resQ.size() + dropQ.size(), 0);
    idle(3);
  endtask

  task automatic chkAllZero(input string name);
    chk({name, "_box"}, int'({oX_MIN, oX_MAX, oY_MIN, oY_MAX}), 0);
    chk({name, "_cnt"}, int'(oCNT), 0);
    chk({name, "_cent"}, int'({oCX, oCY}), 0);
    chk({name, "_flags"}, int'({oFOUND, oVALID, oDROP, oOVL}), 0);
  endtask

  // monitor: every oVALID / oDROP cycle must match the head of its queue
  always @(negedge iCLK) begin
    if (iRST_N && oVALID) begin
      chk("valid_expected", int'(resQ.size() > 0), 1);
      if (resQ.size() > 0) begin
        resT e;
        e = resQ.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("x_min", int'(oX_MIN), e.xmin);
        chk("x_max", int'(oX_MAX), e.xmax);
        chk("y_min", int'(oY_MIN), e.ymin);
        chk("y_max", int'(oY_MAX), e.ymax);
        chk("cnt", int'(oCNT), e.cnt);
        chk("cx", int'(oCX), e.cx);
        chk("cy", int'(oCY), e.cy);
        chk("found", int'(oFOUND), e.found);
      end
    end
    if (iRST_N && oDROP) begin
      chk("drop_expected", int'(dropQ.size() > 0), 1);
      if (dropQ.size() > 0) chk("drop_cycle", cyc, dropQ.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    iRST_N = 1'b1;
    idle(2);
    @(negedge iCLK);
    chkAllZero("reset");
    idle(70);
    @(negedge iCLK);
    chkAllZero("idle_no_frames");

    // 10x10 block: centroid floor(104.5)=104, floor(204.5)=204
    block10();
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(100, 109, 200, 209, 100, 104, 204, 1, lastEdge + 59);
    drain("drain_block");

    // overlay: (100,205) lies on the left edge, (104,205) is interior
    pix(1'b1, 100, 205, 1'b0, 1'b0);
    @(negedge iCLK);
`ifdef BBOX_OVERLAY_EN
    chk("ovl_edge", int'(oOVL), 1);
`else
    chk("ovl_off", int'(oOVL), 0);
`endif
    pix(1'b1, 104, 205, 1'b0, 1'b0);
    @(negedge iCLK);
    chk("ovl_interior", int'(oOVL), 0);

    // empty frame: raw init box, zero centroid
    for (int x = 0; x < 8; x++) pix(1'b1, x * 50, 30, 1'b0, 1'b0);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(1023, 0, 1023, 0, 0, 0, 0, 0, lastEdge + 59);
    drain("drain_empty");

    // 63 pixels x=20..82: sum 3213 -> 51, not found
    rowRun(10, 20, 82);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(20, 82, 10, 10, 63, 51, 10, 0, lastEdge + 59);
    drain("drain_63");

    // 64 pixels x=20..83: sum 3296 -> 51, found
    rowRun(10, 20, 83);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(20, 83, 10, 10, 64, 51, 10, 1, lastEdge + 59);
    drain("drain_64");

    // corners, second pixel on the iEOF edge itself: 639/2 -> 319, 479/2 -> 239
    pix(1'b1, 0, 0, 1'b1, 1'b0);
    pix(1'b1, 639, 479, 1'b1, 1'b1);
    expRes(0, 639, 0, 479, 2, 319, 239, 0, lastEdge + 59);
    drain("drain_corner");

    // second iEOF 20 cycles after the first: dropped, first result unaffected
    block10();
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(100, 109, 200, 209, 100, 104, 204, 1, lastEdge + 59);
    pix(1'b1, 300, 300, 1'b1, 1'b0);   // belongs to the discarded frame
    idle(18);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    dropQ.push_back(lastEdge);
    pix(1'b1, 7, 9, 1'b1, 1'b0);       // next frame starts from zero
    drain("drain_drop");
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(7, 7, 9, 9, 1, 7, 9, 0, lastEdge + 59);
    drain("drain_after_drop");
    idle(10);
    @(negedge iCLK);
    chk("hold_cnt", int'(oCNT), 1);
    chk("hold_cx", int'(oCX), 7);

    // reset during DIV_Y: no result, outputs cleared, accumulators cleared
    rowRun(3, 1, 5);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    pix(1'b1, 500, 400, 1'b1, 1'b0);
    idle(38);
    iRST_N = 1'b0;
    #1;
    chkAllZero("mid_div_reset");
    idle(2);
    iRST_N = 1'b1;
    idle(80);
    @(negedge iCLK);
    chkAllZero("after_reset");

    // recovery frame
    rowRun(10, 20, 83);
    pix(1'b0, 0, 0, 1'b0, 1'b1);
    expRes(20, 83, 10, 10, 64, 51, 10, 1, lastEdge + 59);
    drain("drain_recovery");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
